// File: rtl/spec_pkg.sv
// rtl/spec_pkg.sv - shared channel/direction codes, state type and default widths
package spec_pkg;

  localparam int CH_L = 0;
  localparam int CH_R = 1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT
  } stateT;

  localparam int DEF_BAR_W  = 7;
  localparam int DEF_H_W    = 3;
  localparam int DEF_FRAC_W = 6;
  localparam int DEF_NUM_CH = 2;

endpackage

// File: rtl/spec_div.sv
// rtl/spec_div.sv - sequential restoring divider, one quotient bit per cycle
module spec_div #(
  parameter int DVD_W = 13,
  parameter int DVS_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [DVD_W-1:0] Dividend,
  input  logic [DVS_W-1:0] Divisor,
  output logic             Done,
  output logic [DVD_W-1:0] Quo
);

  localparam int C_W = $clog2(DVD_W + 1);

  // work shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [DVD_W-1:0] work;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [C_W-1:0]   cnt;
  logic             running;
  logic [DVS_W:0]   trial;
  logic             fits;

  always_comb begin
    trial = {rem, work[DVD_W-1]};
    fits  = (trial >= {1'b0, dvs});
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      work    <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Start) begin
        work    <= Dividend;
        rem     <= '0;
        dvs     <= Divisor;
        cnt     <= C_W'(DVD_W);
        running <= 1'b1;
      end else if (running) begin
        if (fits) begin
          rem  <= DVS_W'(trial - {1'b0, dvs});
          work <= {work[DVD_W-2:0], 1'b1};
        end else begin
          rem  <= trial[DVS_W-1:0];
          work <= {work[DVD_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == C_W'(1)) begin
          running <= 1'b0;
          Done    <= 1'b1;
        end
      end
    end
  end

  assign Quo = work;

endmodule

// File: rtl/spectrum_interpolator.sv
// rtl/spectrum_interpolator.sv - per-channel linear bar interpolator feeding the sprite writer
// Define SPECINTERP_ROUND_EN for round-half-up intermediates; default truncates.
module spectrum_interpolator
  import spec_pkg::*;
#(
  parameter int BAR_W  = DEF_BAR_W,
  parameter int H_W    = DEF_H_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Thru,
  input  logic [CH_W-1:0]  Ch,
  input  logic [BAR_W-1:0] InBar,
  input  logic [H_W-1:0]   H,
  input  logic             SWBusy,
  output logic             SWStart,
  output logic             Busy,
  output logic [BAR_W-1:0] OutBar,
  output logic [CH_W-1:0]  OutCh
);

  localparam int Q_W = BAR_W + FRAC_W;
  localparam int P_W = Q_W + H_W;
  localparam int N_W = H_W + 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
`ifdef SPECINTERP_ROUND_EN
  localparam logic [P_W-1:0] HALF = P_W'(1) << (FRAC_W - 1);
`else
  localparam logic [P_W-1:0] HALF = '0;
`endif

  stateT            state;
  logic             startQ;
  logic             thruMode;
  logic [CH_W-1:0]  capCh;
  logic [BAR_W-1:0] capIn;
  logic [BAR_W-1:0] capPrev;
  logic [N_W-1:0]   capN;
  logic [N_W-1:0]   k;
  logic             dir;
  logic [Q_W-1:0]   step;
  logic             divStart;
  logic             divDone;
  logic [Q_W-1:0]   divQuo;
  logic [BAR_W-1:0] prevMem [NUM_CH];

  logic             startEdge;
  logic [CH_W-1:0]  chEff;
  logic [BAR_W-1:0] delta;
  logic [P_W-1:0]   prodR;
  logic [BAR_W-1:0] offs;
  logic [BAR_W-1:0] interp;

  always_comb begin
    startEdge = Start & ~startQ;
    chEff     = ({1'b0, Ch} < NUM_CH_L) ? Ch : '0;
    delta     = (capIn > capPrev) ? (capIn - capPrev) : (capPrev - capIn);
    prodR     = P_W'(step) * P_W'(k[H_W-1:0]) + HALF;
    offs      = BAR_W'(prodR >> FRAC_W);
    // the final step lands on the new bar exactly, independent of quotient error
    if (k == capN)        interp = capIn;
    else if (dir == DIR_UP) interp = capPrev + offs;
    else                  interp = capPrev - offs;
  end

  spec_div #(
    .DVD_W(Q_W),
    .DVS_W(N_W)
  ) uDiv (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (divStart),
    .Dividend({delta, {FRAC_W{1'b0}}}),
    .Divisor (capN),
    .Done    (divDone),
    .Quo     (divQuo)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      startQ   <= 1'b0;
      thruMode <= 1'b0;
      SWStart  <= 1'b0;
      Busy     <= 1'b0;
      OutBar   <= '0;
      OutCh    <= '0;
      divStart <= 1'b0;
      capCh    <= '0;
      capIn    <= '0;
      capPrev  <= '0;
      capN     <= '0;
      k        <= '0;
      dir      <= DIR_DOWN;
      step     <= '0;
      for (int i = 0; i < NUM_CH; i++) prevMem[i] <= '0;
    end else begin
      startQ   <= Start;
      SWStart  <= 1'b0;
      divStart <= 1'b0;
      // bypass keeps Busy up across its own pulse and then tracks the writer
      if (thruMode) begin
        Busy <= SWStart | SWBusy;
        if (!SWStart && !SWBusy) thruMode <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (startEdge && !Busy) begin
            Busy <= 1'b1;
            if (Thru) begin
              OutBar         <= InBar;
              OutCh          <= chEff;
              SWStart        <= 1'b1;
              thruMode       <= 1'b1;
              prevMem[chEff] <= InBar;
            end else begin
              capCh   <= chEff;
              capIn   <= InBar;
              capPrev <= prevMem[chEff];
              dir     <= (InBar > prevMem[chEff]) ? DIR_UP : DIR_DOWN;
              capN    <= N_W'(H) + 1'b1;
              k       <= N_W'(1);
              step    <= '0;
              if (H == '0) begin
                state <= EMIT;
              end else begin
                state    <= DIV;
                divStart <= 1'b1;
              end
            end
          end
        end
        DIV: begin
          if (divDone) begin
            step  <= divQuo;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (SWStart) begin
            if (k > capN) begin
              state          <= IDLE;
              Busy           <= 1'b0;
              prevMem[capCh] <= capIn;
            end
          end else if (!SWBusy) begin
            SWStart <= 1'b1;
            OutBar  <= interp;
            OutCh   <= capCh;
            k       <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_interpolator.sv
// tb/tb_spectrum_interpolator.sv - randomized and directed bench with reference model
module tb_spectrum_interpolator;
  import spec_pkg::*;

  localparam int BAR_W  = 7;
  localparam int H_W    = 3;
  localparam int FRAC_W = 6;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
`ifdef SPECINTERP_ROUND_EN
  localparam int RND = 1 << (FRAC_W - 1);
`else
  localparam int RND = 0;
`endif

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Start;
  logic             Thru;
  logic [CH_W-1:0]  Ch;
  logic [BAR_W-1:0] InBar;
  logic [H_W-1:0]   H;
  logic             SWBusy = 1'b0;
  logic             SWStart;
  logic             Busy;
  logic [BAR_W-1:0] OutBar;
  logic [CH_W-1:0]  OutCh;

  int   total = 0;
  int   bad = 0;
  int   wrDur = 1;
  int   wrCnt = 0;
  logic stallHold = 1'b0;
  int   obsBar[$];
  int   obsCh[$];
  int   expBar[$];
  int   expCh[$];
  int   mPrev[NUM_CH];
  int   ft;

  always #5 Clock = ~Clock;

  spectrum_interpolator #(
    .BAR_W (BAR_W),
    .H_W   (H_W),
    .FRAC_W(FRAC_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Thru   (Thru),
    .Ch     (Ch),
    .InBar  (InBar),
    .H      (H),
    .SWBusy (SWBusy),
    .SWStart(SWStart),
    .Busy   (Busy),
    .OutBar (OutBar),
    .OutCh  (OutCh)
  );

  // sprite writer: busy for wrDur cycles starting the cycle after each draw request
  always @(negedge Clock) begin
    if (wrCnt > 0) begin
      SWBusy = 1'b1;
      wrCnt--;
    end else begin
      SWBusy = stallHold;
    end
    if (SWStart) wrCnt = wrDur;
  end

  always @(negedge Clock) begin
    if (SWStart) begin
      obsBar.push_back(int'(OutBar));
      obsCh.push_back(int'(OutCh));
    end
  end

  task automatic checkVal(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clock);
    #1;
  endtask

  // expected draw list from the interpolation rule, integer arithmetic only
  task automatic modelReq(input int ch, input int bar, input int h, input int thru);
    int p;
    int n;
    int dlt;
    int stp;
    int off;
    p = mPrev[ch];
    if (thru == 0) begin
      n   = h + 1;
      dlt = (bar > p) ? bar - p : p - bar;
      stp = (dlt * (1 << FRAC_W)) / n;
      for (int kk = 1; kk < n; kk++) begin
        off = (kk * stp + RND) >> FRAC_W;
        expBar.push_back((bar > p) ? p + off : p - off);
        expCh.push_back(ch);
      end
    end
    expBar.push_back(bar);
    expCh.push_back(ch);
    mPrev[ch] = bar;
  endtask

  task automatic doReq(input int ch, input int bar, input int h, input int thru,
                       input int dropAt, input int stallAfter, output int firstTick);
    int expN;
    int finalTick;
    int i;
    int n0;
    int held;
    bit done;
    bit stalled;
    obsBar.delete();
    obsCh.delete();
    modelReq(ch, bar, h, thru);
    expN      = expBar.size();
    Ch        = CH_W'(ch);
    InBar     = BAR_W'(bar);
    H         = H_W'(h);
    Thru      = thru[0];
    Start     = 1'b1;
    firstTick = 0;
    finalTick = 0;
    done      = 1'b0;
    stalled   = 1'b0;
    i         = 0;
    while (!done && i < 800) begin
      tick();
      i++;
      if (i == 1) begin
        Start = 1'b0;
        if (thru == 0) checkVal("busy_rise", int'(Busy), 1);
      end
      if (dropAt != 0 && i == dropAt) begin
        Start = 1'b1;
        checkVal("drop_busy", int'(Busy), 1);
      end
      if (dropAt != 0 && i == dropAt + 1) Start = 1'b0;
      if (firstTick == 0 && obsBar.size() > 0) firstTick = i;
      if (stallAfter > 0 && !stalled && obsBar.size() == stallAfter) begin
        stalled   = 1'b1;
        stallHold = 1'b1;
        held      = int'(OutBar);
        n0        = obsBar.size();
        repeat (20) tick();
        i += 20;
        checkVal("stall_pulses", obsBar.size(), n0);
        checkVal("stall_hold", int'(OutBar), held);
        stallHold = 1'b0;
      end
      if (finalTick == 0 && obsBar.size() >= expN) begin
        finalTick = i;
        if (thru == 0) checkVal("busy_last", int'(Busy), 1);
      end else if (finalTick != 0 && i == finalTick + 1 && thru == 0) begin
        checkVal("busy_fall", int'(Busy), 0);
      end
      if (finalTick != 0 && i > finalTick + 1 && !Busy && !SWBusy) done = 1'b1;
    end
    if (!done) checkVal("timeout", 0, 1);
    repeat (3) tick();
    checkVal("npulse", obsBar.size(), expN);
    for (int j = 0; j < expN && j < obsBar.size(); j++) begin
      checkVal($sformatf("bar%0d", j), obsBar[j], expBar[j]);
      checkVal($sformatf("ch%0d", j), obsCh[j], expCh[j]);
    end
    expBar.delete();
    expCh.delete();
    obsBar.delete();
    obsCh.delete();
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Thru  = 1'b0;
    Ch    = '0;
    InBar = '0;
    H     = '0;
    for (int c = 0; c < NUM_CH; c++) mPrev[c] = 0;
    repeat (3) tick();
    checkVal("rst_swstart", int'(SWStart), 0);
    checkVal("rst_busy", int'(Busy), 0);
    checkVal("rst_outbar", int'(OutBar), 0);
    checkVal("rst_outch", int'(OutCh), 0);
    Reset = 1'b0;
    tick();

    wrDur = 2;
    doReq(CH_L, 10, 0, 1, 0, 0, ft);
    checkVal("thru_tick", ft, 1);
    doReq(CH_L, 40, 2, 0, 0, 0, ft);
    checkVal("div_tick_min", int'(ft >= 15), 1);
    doReq(CH_R, 40, 0, 1, 0, 0, ft);
    doReq(CH_R, 0, 3, 0, 0, 0, ft);
    doReq(CH_L, 70, 2, 0, 0, 0, ft);
    doReq(CH_L, 0, 0, 1, 0, 0, ft);
    doReq(CH_L, 5, 2, 0, 0, 0, ft);

    wrDur = 1;
    doReq(CH_R, 77, 0, 0, 0, 0, ft);
    checkVal("h0_tick", ft, 2);
    wrDur = 3;
    doReq(CH_L, 77, 0, 1, 2, 0, ft);
    checkVal("thru77_tick", ft, 1);
    doReq(CH_R, 120, 5, 0, 6, 0, ft);

    wrDur = 1;
    doReq(CH_R, 20, 3, 0, 0, 1, ft);

    Ch    = CH_W'(CH_R);
    InBar = BAR_W'(100);
    H     = H_W'(5);
    Thru  = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    checkVal("mid_rst_swstart", int'(SWStart), 0);
    checkVal("mid_rst_busy", int'(Busy), 0);
    checkVal("mid_rst_outbar", int'(OutBar), 0);
    checkVal("mid_rst_outch", int'(OutCh), 0);
    Reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) mPrev[c] = 0;
    obsBar.delete();
    obsCh.delete();
    repeat (30) tick();
    checkVal("no_stale", obsBar.size(), 0);
    doReq(CH_R, 8, 1, 0, 0, 0, ft);
    doReq(CH_L, 127, 7, 0, 0, 0, ft);
    doReq(CH_L, 0, 7, 0, 0, 0, ft);

    for (int r = 0; r < 25; r++) begin
      wrDur = int'($urandom_range(1, 3));
      doReq(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, (1 << BAR_W) - 1)),
            int'($urandom_range(0, (1 << H_W) - 1)), int'($urandom_range(0, 5) == 0), 0, 0, ft);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spectrum_interpolator.md
# spectrum_interpolator

Parametrised per-channel spectrum bar interpolator between the FFT bar quantiser and the sprite writer. For each new bar value it emits H linearly interpolated intermediate bars, then the new bar itself, stepping from that channel's previous bar toward the new one. Each output is handed to the sprite writer through the SWStart/SWBusy handshake. It generalises the single-channel complementer with:
- parametrised bar, step and fraction widths;
- NUM_CH independent previous-bar histories;
- exact endpoint output;
- selectable rounding.

## Interface
Parameters:
- BAR_W, 7, bar magnitude width
- H_W, 3, width of step-count input H (max H = 2^H_W-1)
- FRAC_W, 6, fixed-point fraction bits of the step size
- NUM_CH, 2, channel count; CH_W = max(1, clog2(NUM_CH))

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  level; rising edge (0→1 across consecutive cycles) requests one bar
- Thru  in  1  bypass interpolation
- Ch  in  CH_W  channel of InBar, sampled on Start edge
- InBar  in  BAR_W  new bar value, sampled on Start edge
- H  in  H_W  intermediate bar count, sampled on Start edge
- SWBusy  in  1  sprite writer busy
- SWStart  out  1  one-cycle draw request
- Busy  out  1  request in progress
- OutBar  out  BAR_W  bar to draw, valid with SWStart, held until next update
- OutCh  out  CH_W  channel of OutBar

## Operation
- Edge detect uses a registered copy of Start. An edge is accepted only when Busy=0 and state is IDLE; otherwise it is dropped silently.
- States: IDLE → DIV → EMIT → IDLE.
  - Accepted edge with Thru=0: capture Ch, InBar, H, Prev=prev[Ch].
  - delta = |InBar−Prev|; dir = up if InBar > Prev.
  - N = H+1.
- DIV: step = (delta·2^FRAC_W)/N, unsigned quotient of width BAR_W+FRAC_W.
  - H=0 skips DIV: state goes directly to EMIT with N=1.
- EMIT, k = 1..N in order:
  - For k<N: OutBar = Prev ± ((k·step [+2^(FRAC_W−1)]) >> FRAC_W).
  - k·step is computed at BAR_W+FRAC_W+H_W bits.
  - For k=N: OutBar = InBar exactly.
  - After the k=N pulse: prev[Ch] ← InBar; state → IDLE.
- SWStart is asserted only in a cycle where state=EMIT, SWStart=0 and SWBusy=0. Minimum pulse spacing is therefore 2 cycles.
- The sprite writer must raise SWBusy in the cycle after SWStart.
- delta=0: all N outputs equal Prev.
- Thru=1 on an accepted edge:
  - OutBar=InBar and OutCh=Ch, registered.
  - SWStart pulses once, the cycle after the edge.
  - Busy mirrors SWBusy.
  - prev[Ch] ← InBar.
  - No DIV/EMIT.
- Ch ≥ NUM_CH: the request is accepted but treated as channel 0.
- Reset (including mid-DIV or mid-EMIT): state IDLE; all prev[] = 0; SWStart=0, Busy=0, OutBar=0, OutCh=0. Any request in flight is discarded.

## Timing
- Edge at cycle t (Start=1, registered Start=0): capture at the end of t; Busy=1 from t+1.
- Divider latency is BAR_W+FRAC_W cycles, one quotient bit per cycle. With defaults, the first SWStart is no earlier than t+1+13+1 = t+15.
- H=0: first SWStart at t+2 (if SWBusy=0).
- Busy falls the cycle after the final (k=N) SWStart pulse. A new edge is accepted from that cycle.
- SWBusy held high stalls EMIT indefinitely with outputs held; no timeout.
- Thru: SWStart at t+1; Busy=SWBusy registered each cycle.

## Configuration
- SPECINTERP_ROUND_EN defined: intermediates add 2^(FRAC_W−1) before the shift (round half up).
- Undefined: truncate.
- The endpoint k=N is exact in both cases.

## Structure
- Shared package spec_pkg holds:
  - CH_L=0, CH_R=1;
  - DIR_DOWN=0, DIR_UP=1;
  - state enum IDLE/DIV/EMIT;
  - default widths.
- Sub-module spec_div: sequential restoring divider.
  - Dividend BAR_W+FRAC_W bits, divisor H_W+1 bits.
  - Start pulse in; Done pulse and Quo out.
  - Synchronous reset.

## Test plan
- Prev[L]=10, InBar=40, H=2, Thru=0 → step=640; SWStart×3 with OutBar 20, 30, 40; prev[L]=40; Busy falls after the 3rd pulse.
- Prev[R]=40, InBar=0, H=3 → OutBar 30, 20, 10, 0 on channel R; prev[L] unchanged.
- Prev=0, InBar=5, H=2 → with SPECINTERP_ROUND_EN: 2, 3, 5; without: 1, 3, 5.
- H=0 and Thru=1 variants, InBar=77 → single SWStart with OutBar=77; Thru pulse at t+1; second Start edge while Busy → dropped, no extra pulse.
- SWBusy held high 20 cycles during EMIT → no SWStart, OutBar held; on release, the sequence resumes with no value skipped or repeated.
- Reset asserted mid-DIV → next cycle all outputs 0, prev[]=0; a subsequent request InBar=8, H=1 yields 4, 8.
